// File: rtl/weight_sram_arb_pkg.sv
// Shared widths, request records and grant encoding for the weight SRAM arbiter.
package weight_sram_arb_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int BYTE_W = 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
   } rd_req_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_WR,
      GNT_RD
   } grant_e;

   // Q0 is the most significant byte of the returned word.
   function automatic logic [DATA_W-1:0] pack_q(
      input logic [BYTE_W-1:0] q0,
      input logic [BYTE_W-1:0] q1,
      input logic [BYTE_W-1:0] q2,
      input logic [BYTE_W-1:0] q3
   );
      return {q0, q1, q2, q3};
   endfunction

endpackage

// File: rtl/weight_sram_arbiter_if.sv
// Request ports, response port and SRAM pins of the weight SRAM arbiter.
interface weight_sram_arbiter_if;
   import weight_sram_arb_pkg::*;

   logic              wr_req_valid;
   logic              wr_req_ready;
   logic [ADDR_W-1:0] wr_req_addr;
   logic [DATA_W-1:0] wr_req_data;

   logic              rd_req_valid;
   logic              rd_req_ready;
   logic [ADDR_W-1:0] rd_req_addr;

   logic              rd_rsp_valid;
   logic              rd_rsp_ready;
   logic [DATA_W-1:0] rd_rsp_data;

   logic              sram_ceb;
   logic              sram_web;
   logic [ADDR_W-1:0] sram_a;
   logic [DATA_W-1:0] sram_d;
   logic [BYTE_W-1:0] sram_q0;
   logic [BYTE_W-1:0] sram_q1;
   logic [BYTE_W-1:0] sram_q2;
   logic [BYTE_W-1:0] sram_q3;

   modport slave (
      input  wr_req_valid, wr_req_addr, wr_req_data,
      input  rd_req_valid, rd_req_addr, rd_rsp_ready,
      input  sram_q0, sram_q1, sram_q2, sram_q3,
      output wr_req_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data,
      output sram_ceb, sram_web, sram_a, sram_d
   );

   modport master (
      output wr_req_valid, wr_req_addr, wr_req_data,
      output rd_req_valid, rd_req_addr, rd_rsp_ready,
      output sram_q0, sram_q1, sram_q2, sram_q3,
      input  wr_req_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data,
      input  sram_ceb, sram_web, sram_a, sram_d
   );

endinterface

// File: rtl/weight_sram_rsp_fifo.sv
// In-order read response FIFO; head reads as zero while empty.
module weight_sram_rsp_fifo
   import weight_sram_arb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = DATA_W,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] occupancy
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign valid   = (occupancy != '0);
   assign full    = (occupancy == CNT_W'(DEPTH));
   assign do_pop  = pop & valid;
   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign head    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge CLK) begin
      if (do_push && !RST) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   occupancy <= occupancy + CNT_W'(1);
            2'b01:   occupancy <= occupancy - CNT_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

endmodule

// File: rtl/weight_sram_arbiter.sv
// Round-robin write/read arbiter for the single-port weight SRAM with a
// credit-checked read response FIFO.
module weight_sram_arbiter
   import weight_sram_arb_pkg::*;
#(
   parameter int RSP_DEPTH = 2
) (
   input logic                  CLK,
   input logic                  RST,
   weight_sram_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(RSP_DEPTH + 1);

   wr_req_t          wr_req;
   rd_req_t          rd_req;
   grant_e           grant;
   logic             last_grant_rd;
   logic             inflight;
   logic             rsp_valid;
   logic             pop;
   logic [CNT_W-1:0] occupancy;
   logic [CNT_W:0]   committed;
   logic             rd_elig;
   logic             wr_elig;

   assign wr_req = {bus.wr_req_addr, bus.wr_req_data};
   assign rd_req = bus.rd_req_addr;

   assign pop = rsp_valid & bus.rd_rsp_ready;

   // Slots already owed to the consumer, crediting a head leaving this cycle.
   assign committed = {1'b0, occupancy} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);

   assign wr_elig = bus.wr_req_valid;
   assign rd_elig = bus.rd_req_valid & (committed < (CNT_W + 1)'(RSP_DEPTH));

   always_comb begin
      grant = GNT_NONE;
      if (!RST) begin
         if (wr_elig && rd_elig) begin
            grant = last_grant_rd ? GNT_WR : GNT_RD;
         end else if (wr_elig) begin
            grant = GNT_WR;
         end else if (rd_elig) begin
            grant = GNT_RD;
         end
      end
   end

   assign bus.wr_req_ready = (grant == GNT_WR);
   assign bus.rd_req_ready = (grant == GNT_RD);

   always_comb begin
      bus.sram_ceb = 1'b1;
      bus.sram_web = 1'b1;
      bus.sram_a   = '0;
      bus.sram_d   = '0;
      unique case (grant)
         GNT_WR: begin
            bus.sram_ceb = 1'b0;
            bus.sram_web = 1'b0;
            bus.sram_a   = wr_req.addr;
            bus.sram_d   = wr_req.data;
         end
         GNT_RD: begin
            bus.sram_ceb = 1'b0;
            bus.sram_a   = rd_req.addr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         last_grant_rd <= 1'b1;
         inflight      <= 1'b0;
      end else begin
         inflight <= (grant == GNT_RD);
         if (grant == GNT_WR) last_grant_rd <= 1'b0;
         if (grant == GNT_RD) last_grant_rd <= 1'b1;
      end
   end

   // Q is valid the cycle after a read grant; a read cut short by reset is dropped.
   weight_sram_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (inflight & ~RST),
      .push_data (pack_q(bus.sram_q0, bus.sram_q1, bus.sram_q2, bus.sram_q3)),
      .pop       (pop),
      .valid     (rsp_valid),
      .head      (bus.rd_rsp_data),
      .occupancy (occupancy)
   );

   assign bus.rd_rsp_valid = rsp_valid;

endmodule

// File: tb/tb_weight_sram_arbiter.sv
// Randomised and directed bench for weight_sram_arbiter against a grant-order reference model.
module tb_weight_sram_arbiter;
   import weight_sram_arb_pkg::*;

   localparam int DEPTH = 2;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   weight_sram_arbiter_if bus();

   weight_sram_arbiter #(.RSP_DEPTH(DEPTH)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // Behavioural SRAM: write or registered read when CEB is low.
   logic [31:0] sram_mem [4096];
   always @(posedge CLK) begin
      if (!bus.sram_ceb) begin
         if (!bus.sram_web) sram_mem[bus.sram_a] <= bus.sram_d;
         else {bus.sram_q0, bus.sram_q1, bus.sram_q2, bus.sram_q3} <= sram_mem[bus.sram_a];
      end
   end

   typedef struct {
      logic [31:0] data;
      int          due;
   } rsp_t;

   logic [31:0] ref_mem [4096];
   rsp_t        rsp_q[$];
   logic [31:0] obs_pops[$];
   bit          ref_last_rd = 1'b1;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   bit          obs_wr;
   bit          obs_rd;
   bit          obs_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive, predict from the model, compare, then advance the model.
   task automatic step(input bit wv, input logic [11:0] wa, input logic [31:0] wd,
                       input bit rv, input logic [11:0] ra, input bit rr, input bit rs);
      bit     exp_valid;
      bit     exp_pop;
      bit     rd_ok;
      int     pending;
      grant_e g;
      RST              = rs;
      bus.wr_req_valid = wv;
      bus.wr_req_addr  = wa;
      bus.wr_req_data  = wd;
      bus.rd_req_valid = rv;
      bus.rd_req_addr  = ra;
      bus.rd_rsp_ready = rr;
      @(negedge CLK);
      exp_valid = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
      exp_pop   = exp_valid && rr;
      pending   = rsp_q.size() - (exp_pop ? 1 : 0);
      rd_ok     = rv && (pending < DEPTH);
      g = GNT_NONE;
      if (!rs) begin
         if (wv && rd_ok) g = ref_last_rd ? GNT_WR : GNT_RD;
         else if (wv)     g = GNT_WR;
         else if (rd_ok)  g = GNT_RD;
      end
      obs_wr    = bus.wr_req_ready;
      obs_rd    = bus.rd_req_ready;
      obs_valid = bus.rd_rsp_valid;
      check("wr_req_ready", bus.wr_req_ready, g == GNT_WR);
      check("rd_req_ready", bus.rd_req_ready, g == GNT_RD);
      check("sram_ceb", bus.sram_ceb, g == GNT_NONE);
      check("sram_web", bus.sram_web, g != GNT_WR);
      check("sram_a", bus.sram_a, (g == GNT_WR) ? wa : (g == GNT_RD) ? ra : 12'h000);
      check("sram_d", bus.sram_d, (g == GNT_WR) ? wd : 32'h0);
      check("rd_rsp_valid", bus.rd_rsp_valid, exp_valid);
      if (exp_valid) check("rd_rsp_data", bus.rd_rsp_data, rsp_q[0].data);
      if (bus.rd_rsp_valid && rr) obs_pops.push_back(bus.rd_rsp_data);
      if (rs) begin
         rsp_q.delete();
         ref_last_rd = 1'b1;
      end else begin
         if (exp_pop) void'(rsp_q.pop_front());
         if (g == GNT_WR) begin
            ref_mem[wa] = wd;
            ref_last_rd = 1'b0;
         end else if (g == GNT_RD) begin
            rsp_q.push_back('{data: ref_mem[ra], due: cyc + 2});
            ref_last_rd = 1'b1;
         end
      end
      cyc++;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b1, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      int idx;
      int steps;
      for (int i = 0; i < 4096; i++) begin
         sram_mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
         ref_mem[i]  = (i * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
      end
      bus.wr_req_valid = 1'b0;
      bus.wr_req_addr  = '0;
      bus.wr_req_data  = '0;
      bus.rd_req_valid = 1'b0;
      bus.rd_req_addr  = '0;
      bus.rd_rsp_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;

      // Reset values with both requests asserted
      step(1'b1, 12'h123, 32'hFFFF_FFFF, 1'b1, 12'h456, 1'b1, 1'b1);
      check("rst_rsp_data", bus.rd_rsp_data, 32'h0);
      check("rst_rsp_valid", bus.rd_rsp_valid, 1'b0);

      // Write then read the same word
      obs_pops.delete();
      step(1'b1, 12'h005, 32'hA1B2_C3D4, 1'b0, 12'h0, 1'b1, 1'b0);
      step(1'b0, 12'h0, 32'h0, 1'b1, 12'h005, 1'b1, 1'b0);
      idle(1);
      check("wr_rd_valid", bus.rd_rsp_valid, 1'b1);
      check("wr_rd_q0", bus.rd_rsp_data[31:24], 8'hA1);
      idle(2);
      check("wr_rd_pops", obs_pops.size(), 1);
      if (obs_pops.size() > 0) check("wr_rd_data", obs_pops[0], 32'hA1B2_C3D4);

      // Contention from reset: WR first, then alternate
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 12'(16 + i), $urandom, 1'b1, 12'(32 + i), 1'b1, 1'b0);
         check("contention_wr", obs_wr, (i % 2) == 0);
         check("contention_rd", obs_rd, (i % 2) == 1);
      end
      idle(3);

      // Backpressure: only DEPTH reads fit while the consumer stalls
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 12'h0, 32'h0, 1'b1, 12'(40 + i), 1'b0, 1'b0);
         if (obs_rd) cnt++;
      end
      check("bp_rd_grants", cnt, 2);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 12'(60 + i), $urandom, 1'b1, 12'(45 + i), 1'b0, 1'b0);
         check("bp_wr_proceeds", obs_wr, 1'b1);
         check("bp_rd_blocked", obs_rd, 1'b0);
      end
      obs_pops.delete();
      for (int k = 0; k < 10 && rsp_q.size() > 0; k++) idle(1);
      check("bp_drain_model", rsp_q.size(), 0);
      check("bp_drain_pops", obs_pops.size(), 2);
      if (obs_pops.size() == 2) begin
         check("bp_order0", obs_pops[0], ref_mem[40]);
         check("bp_order1", obs_pops[1], ref_mem[41]);
      end
      step(1'b0, 12'h0, 32'h0, 1'b1, 12'd42, 1'b1, 1'b0);
      check("bp_resume", obs_rd, 1'b1);
      idle(3);

      // Streaming reads at 0..15
      obs_pops.delete();
      idx = 0;
      steps = 0;
      while (idx < 16 && steps < 40) begin
         step(1'b0, 12'h0, 32'h0, 1'b1, 12'(idx), 1'b1, 1'b0);
         if (obs_rd) idx++;
         steps++;
      end
      check("stream_steps", steps, 16);
      idle(4);
      check("stream_pops", obs_pops.size(), 16);
      for (int i = 0; i < 16 && i < obs_pops.size(); i++) check("stream_data", obs_pops[i], ref_mem[i]);

      // Reset in the cycle after a read grant
      step(1'b0, 12'h0, 32'h0, 1'b1, 12'h077, 1'b1, 1'b0);
      check("midrst_grant", obs_rd, 1'b1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         idle(1);
         check("midrst_valid", obs_valid, 1'b0);
      end
      check("midrst_occ", dut.u_fifo.occupancy, 0);
      step(1'b1, 12'h078, 32'h0BAD_F00D, 1'b1, 12'h079, 1'b1, 1'b0);
      check("midrst_wr_first", obs_wr, 1'b1);
      idle(3);

      // Address extremes
      obs_pops.delete();
      step(1'b1, 12'hFFF, 32'hDEAD_BEEF, 1'b0, 12'h0, 1'b1, 1'b0);
      step(1'b1, 12'h000, 32'h1234_5678, 1'b0, 12'h0, 1'b1, 1'b0);
      step(1'b0, 12'h0, 32'h0, 1'b1, 12'hFFF, 1'b1, 1'b0);
      step(1'b0, 12'h0, 32'h0, 1'b1, 12'h000, 1'b1, 1'b0);
      idle(3);
      check("ext_pops", obs_pops.size(), 2);
      if (obs_pops.size() == 2) begin
         check("ext_hi", obs_pops[0], 32'hDEAD_BEEF);
         check("ext_lo", obs_pops[1], 32'h1234_5678);
      end

      // Random traffic over a small address pool plus the extremes
      for (int i = 0; i < 800; i++) begin
         logic [11:0] wa;
         logic [11:0] ra;
         wa = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 7));
         ra = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 7));
         step($urandom_range(0, 2) == 0, wa, $urandom,
              $urandom_range(0, 3) != 0, ra,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 99) == 0);
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
